sigmoid_backprop: RTL



---
 rtl/sigmoid_backprop_if.sv | 34 +++
 rtl/sigmoid_backprop.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sigmoid_backprop_if.sv
// Operand/result handshake bundle for sigmoid_backprop.
// With SIGMOID_BP_LR_EN defined, the bundle also carries lr_shift.
interface sigmoid_backprop_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] act_in;
  logic [DATA_W-1:0] err_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] delta_out;
`ifdef SIGMOID_BP_LR_EN
  logic [2:0]        lr_shift;

  modport master (
    output in_valid, act_in, err_in, out_ready, lr_shift,
    input  in_ready, out_valid, delta_out
  );
  modport slave (
    input  in_valid, act_in, err_in, out_ready, lr_shift,
    output in_ready, out_valid, delta_out
  );
`else
  modport master (
    output in_valid, act_in, err_in, out_ready,
    input  in_ready, out_valid, delta_out
  );
  modport slave (
    input  in_valid, act_in, err_in, out_ready,
    output in_ready, out_valid, delta_out
  );
`endif
endinterface

// File: rtl/sigmoid_backprop.sv
// Sigmoid backward pass: delta = err * a * (1 - a), Q8.8, two bit-serial multiplies.
// Optional macro SIGMOID_BP_LR_EN adds lr_shift, giving delta = p2 >>> (8 + lr_shift).
module sigmoid_backprop #(
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sigmoid_backprop_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DATA_W-1:0]  r_ac;
  logic [DATA_W-1:0]  r_err;
  logic [DATA_W-1:0]  r_d;
  logic [DATA_W-1:0]  r_delta;
  logic [3:0]         r_count;
  logic [31:0]        r_acc;
  logic [DATA_W-1:0]  w_ac_clamp;
  logic [DATA_W-1:0]  w_mul1_op;
  logic [31:0]        w_mul1_term;
  logic [31:0]        w_mul2_term;
  logic [31:0]        w_acc_next;
  logic [4:0]         w_shamt;
  logic [DATA_W-1:0]  w_delta_next;
  logic               w_last;

`ifdef SIGMOID_BP_LR_EN
  logic [2:0]         r_lr;
  assign w_shamt = 5'd8 + {2'b00, r_lr};
`else
  assign w_shamt = 5'd8;
`endif

  // Negative activations clamp to 0, anything above 1.0 clamps to 1.0.
  assign w_ac_clamp = bus.act_in[15] ? 16'h0000 :
                      (bus.act_in > 16'h0100) ? 16'h0100 : bus.act_in;

  assign w_mul1_op   = 16'h0100 - r_ac;
  assign w_mul1_term = w_mul1_op[r_count] ? ({16'h0000, r_ac} << r_count) : 32'h0;
  // d is never negative, so adding shifted sign-extended err yields the signed product.
  assign w_mul2_term = r_d[r_count] ? ({{16{r_err[15]}}, r_err} << r_count) : 32'h0;
  assign w_acc_next  = r_acc + ((r_state == MUL1) ? w_mul1_term : w_mul2_term);
  assign w_delta_next = DATA_W'($signed(w_acc_next) >>> w_shamt);
  assign w_last = (r_count == 4'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_state_next = MUL1;
      MUL1: if (w_last) w_state_next = MUL2;
      MUL2: if (w_last) w_state_next = DONE;
      DONE: if (bus.out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
  end

  assign bus.delta_out = r_delta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ac    <= '0;
      r_err   <= '0;
      r_d     <= '0;
      r_delta <= '0;
      r_count <= '0;
      r_acc   <= '0;
`ifdef SIGMOID_BP_LR_EN
      r_lr    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_ac    <= w_ac_clamp;
            r_err   <= bus.err_in;
            r_count <= '0;
            r_acc   <= '0;
`ifdef SIGMOID_BP_LR_EN
            r_lr    <= bus.lr_shift;
`endif
          end
        end
        MUL1: begin
          r_count <= r_count + 4'd1;
          if (w_last) begin
            r_d   <= w_acc_next[23:8];
            r_acc <= '0;
          end else begin
            r_acc <= w_acc_next;
          end
        end
        MUL2: begin
          r_count <= r_count + 4'd1;
          if (w_last) begin
            r_delta <= w_delta_next;
            r_acc   <= '0;
          end else begin
            r_acc <= w_acc_next;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
